// File: rtl/tdc_pkg.sv
// Shared types and stream layout for the TDC frame scheduler.
// State encoding is one-hot over the active states, with IDLE as all-zero.
package tdc_pkg;

  typedef enum logic [4:0] {
    S_IDLE  = 5'b00000,
    S_ARM   = 5'b00001,
    S_FIRE  = 5'b00010,
    S_WAIT  = 5'b00100,
    S_DRAIN = 5'b01000,
    S_GAP   = 5'b10000
  } state_e;

  localparam int unsigned TOF_W   = 10;
  localparam int unsigned INT_W   = 5;
  localparam int unsigned TOF_LSB = 0;
  localparam int unsigned INT_LSB = TOF_LSB + TOF_W;
  localparam int unsigned CH_LSB  = INT_LSB + INT_W;

  function automatic int unsigned ch_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tdc_rr_mux.sv
// Grant-indexed pass-through of one channel's result stream onto the output,
// with the output ready routed back only to the granted channel.
module tdc_rr_mux
  import tdc_pkg::*;
#(
  parameter int unsigned N_CH = 4,
  parameter int unsigned CH_W = ch_width(N_CH)
) (
  input  logic                         en,
  input  logic [CH_W-1:0]              grant,
  input  logic [N_CH-1:0]              ch_valid,
  input  logic [N_CH*TOF_W-1:0]        ch_data,
  input  logic [N_CH*INT_W-1:0]        ch_int,
  input  logic [N_CH-1:0]              ch_last,
  output logic [N_CH-1:0]              ch_ready,
  input  logic                         m_tready,
  output logic                         m_tvalid,
  output logic [CH_W+TOF_W+INT_W-1:0]  m_tdata,
  output logic                         m_tlast
);

  always_comb begin
    ch_ready = '0;
    m_tvalid = 1'b0;
    m_tdata  = '0;
    m_tlast  = 1'b0;
    if (en) begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        if (CH_W'(i) == grant) begin
          ch_ready[i] = m_tready;
          m_tvalid    = ch_valid[i];
          m_tdata     = {grant, ch_int[i*INT_W +: INT_W], ch_data[i*TOF_W +: TOF_W]};
          m_tlast     = ch_last[i];
        end
      end
    end
  end

endmodule

// File: rtl/tdc_frame_sched.sv
// Frame scheduler for a TDC channel array: program range, fire a shared start,
// wait for every channel's end-of-count, then drain results round-robin.
module tdc_frame_sched
  import tdc_pkg::*;
#(
  parameter  int unsigned N_CH     = 4,
  parameter  int unsigned START_W  = 4,
  parameter  int unsigned SETUP    = 2,
  parameter  int unsigned INT_TO   = 1024,
  parameter  int unsigned DRAIN_TO = 8,
  localparam int unsigned CH_W     = ch_width(N_CH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_en,
  input  logic [14:0]         cfg_range,
  input  logic [15:0]         cfg_frames,
  input  logic [15:0]         cfg_period,
  output logic                TDC_start,
  output logic [14:0]         TDC_Range,
  input  logic [N_CH-1:0]     tdc_int,
  input  logic [N_CH-1:0]     ch_valid,
  output logic [N_CH-1:0]     ch_ready,
  input  logic [N_CH*10-1:0]  ch_data,
  input  logic [N_CH*5-1:0]   ch_int,
  input  logic [N_CH-1:0]     ch_last,
  output logic                m_tvalid,
  input  logic                m_tready,
  output logic [CH_W+14:0]    m_tdata,
  output logic                m_tlast,
  output logic                m_tuser,
  output logic                busy,
  output logic [15:0]         frame_cnt,
  output logic                frame_done,
  output logic                err_to,
  output logic                err_ovr
);

  state_e            state_q, state_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [15:0]       per_q, per_d;
  logic [15:0]       idle_q, idle_d;
  logic [CH_W-1:0]   grant_q, grant_d;
  logic [N_CH-1:0]   seen_q, seen_d;
  logic              first_q, first_d;
  logic [14:0]       range_q, range_d;
  logic [15:0]       frame_cnt_q, frame_cnt_d;
  logic              frame_done_q, frame_done_d;
  logic              err_to_q, err_to_d;
  logic              err_ovr_q, err_ovr_d;
  logic              adv;
  logic              hs;
  logic [16:0]       gap_thr;

  tdc_rr_mux #(.N_CH(N_CH), .CH_W(CH_W)) u_mux (
    .en       (state_q == S_DRAIN),
    .grant    (grant_q),
    .ch_valid (ch_valid),
    .ch_data  (ch_data),
    .ch_int   (ch_int),
    .ch_last  (ch_last),
    .ch_ready (ch_ready),
    .m_tready (m_tready),
    .m_tvalid (m_tvalid),
    .m_tdata  (m_tdata),
    .m_tlast  (m_tlast)
  );

  assign hs = m_tvalid & m_tready;

  // GAP exits SETUP+1 cycles early so ARM's setup lands the next start exactly one period later.
  assign gap_thr = ({1'b0, cfg_period} > 17'(SETUP + 1)) ? ({1'b0, cfg_period} - 17'(SETUP + 1)) : '0;

  always_comb begin
    state_d      = state_q;
    cnt_d        = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
    per_d        = (per_q == 16'hFFFF) ? per_q : per_q + 16'd1;
    idle_d       = idle_q;
    grant_d      = grant_q;
    seen_d       = seen_q;
    first_d      = first_q;
    range_d      = range_q;
    frame_cnt_d  = frame_cnt_q;
    frame_done_d = 1'b0;
    err_to_d     = err_to_q;
    err_ovr_d    = err_ovr_q;
    adv          = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cfg_en) begin
          state_d     = S_ARM;
          range_d     = cfg_range;
          frame_cnt_d = '0;
          err_to_d    = 1'b0;
          err_ovr_d   = 1'b0;
        end
      end
      S_ARM: begin
        if (cnt_q == 16'(SETUP - 1)) state_d = S_FIRE;
      end
      S_FIRE: begin
        seen_d = seen_q | tdc_int;
        if (cnt_q == 16'(START_W - 1)) state_d = S_WAIT;
      end
      S_WAIT: begin
        seen_d = seen_q | tdc_int;
        if (&seen_d) begin
          state_d = S_DRAIN;
        end else if (cnt_q == 16'(INT_TO - 1)) begin
          err_to_d = 1'b1;
          state_d  = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (hs) begin
          idle_d  = '0;
          first_d = 1'b0;
          adv     = m_tlast;
        end else if (!m_tvalid) begin
          if (idle_q == 16'(DRAIN_TO - 1)) adv = 1'b1;
          else                             idle_d = idle_q + 16'd1;
        end else begin
          idle_d = '0;
        end
        if (adv) begin
          idle_d = '0;
          if (grant_q == CH_W'(N_CH - 1)) begin
            grant_d      = '0;
            state_d      = S_GAP;
            frame_done_d = 1'b1;
            frame_cnt_d  = frame_cnt_q + 16'd1;
          end else begin
            grant_d = grant_q + CH_W'(1);
          end
        end
      end
      S_GAP: begin
        if (cnt_q == '0 && {1'b0, per_q} > gap_thr) err_ovr_d = 1'b1;
        if ({1'b0, per_q} >= gap_thr) begin
          if (!cfg_en || (cfg_frames != '0 && frame_cnt_q == cfg_frames)) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_ARM;
            range_d = cfg_range;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_FIRE && state_q != S_FIRE) begin
      per_d   = '0;
      seen_d  = '0;
      first_d = 1'b1;
    end
    if (state_d != state_q) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      per_q        <= '0;
      idle_q       <= '0;
      grant_q      <= '0;
      seen_q       <= '0;
      first_q      <= 1'b0;
      range_q      <= '0;
      frame_cnt_q  <= '0;
      frame_done_q <= 1'b0;
      err_to_q     <= 1'b0;
      err_ovr_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      per_q        <= per_d;
      idle_q       <= idle_d;
      grant_q      <= grant_d;
      seen_q       <= seen_d;
      first_q      <= first_d;
      range_q      <= range_d;
      frame_cnt_q  <= frame_cnt_d;
      frame_done_q <= frame_done_d;
      err_to_q     <= err_to_d;
      err_ovr_q    <= err_ovr_d;
    end
  end

  assign TDC_start  = (state_q == S_FIRE);
  assign TDC_Range  = range_q;
  assign m_tuser    = m_tvalid & first_q;
  assign busy       = (state_q != S_IDLE);
  assign frame_cnt  = frame_cnt_q;
  assign frame_done = frame_done_q;
  assign err_to     = err_to_q;
  assign err_ovr    = err_ovr_q;

endmodule
